// File: rtl/seq_alu_if.sv
// Request/response bundle for seq_alu: request channel (in_*, op, a, b)
// and result channel (out_*, result, cmp, illegal).
interface seq_alu_if #(
  parameter int unsigned XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [4:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            cmp;
  logic            illegal;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, cmp, illegal
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, cmp, illegal
  );
endinterface

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle base/compare ops, iterative multiply/divide.
// Build option: define SEQ_ALU_M_EN to include the M-extension datapath;
// without it every op[4]=1 request completes in one cycle flagged illegal.
module seq_alu #(
  parameter int unsigned XLEN = 32
) (
  input  logic     clk,
  input  logic     rst,
  seq_alu_if.slave bus
);
  localparam int unsigned SW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_e;

  state_e          state_q, state_d;
  logic            in_ready_q, out_valid_q;
  logic [XLEN-1:0] result_q, result_d;
  logic            cmp_q, cmp_d;
  logic            illegal_q, illegal_d;
  logic            accept_c;
  logic [XLEN-1:0] base_res_c;
  logic            base_cmp_c;
  logic [SW-1:0]   shamt_c;

  assign accept_c = bus.in_valid && in_ready_q;
  assign shamt_c  = bus.b[SW-1:0];

  // Single-cycle base ALU and branch comparator on the live request.
  always_comb begin
    base_res_c = '0;
    base_cmp_c = 1'b0;
    case (bus.op[3:0])
      4'b0000: base_res_c = bus.a + bus.b;
      4'b0001: base_res_c = bus.a - bus.b;
      4'b0010: base_res_c = bus.a ^ bus.b;
      4'b0011: base_res_c = bus.a | bus.b;
      4'b0100: base_res_c = bus.a & bus.b;
      4'b0101: base_res_c = bus.a << shamt_c;
      4'b0110: base_res_c = bus.a >> shamt_c;
      4'b0111: base_res_c = $unsigned($signed(bus.a) >>> shamt_c);
      4'b1000: base_res_c = {{(XLEN-1){1'b0}}, $signed(bus.a) < $signed(bus.b)};
      4'b1001: base_res_c = {{(XLEN-1){1'b0}}, bus.a < bus.b};
      4'b1010: base_cmp_c = (bus.a == bus.b);
      4'b1011: base_cmp_c = (bus.a != bus.b);
      4'b1100: base_cmp_c = ($signed(bus.a) < $signed(bus.b));
      4'b1101: base_cmp_c = ($signed(bus.a) >= $signed(bus.b));
      4'b1110: base_cmp_c = (bus.a < bus.b);
      4'b1111: base_cmp_c = (bus.a >= bus.b);
    endcase
  end

`ifdef SEQ_ALU_M_EN
  localparam int unsigned CW = SW + 1;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  // hi/lo: product halves for multiply, partial remainder/quotient for divide.
  logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d;
  logic [2:0]        mop_q, mop_d;
  logic              neg_q, neg_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              a_neg_c, b_neg_c, div_zero_c, div_ovf_c;
  logic [XLEN-1:0]   a_mag_c, b_mag_c, early_res_c;
  logic [XLEN-1:0]   iter_hi_c, iter_lo_c, quo_c, rem_c, final_res_c;
  logic [XLEN:0]     sum_c, rs_c, diff_c;
  logic [2*XLEN-1:0] prod_mag_c, prod_c;

  // Operand magnitudes and the divide cases that bypass iteration.
  always_comb begin
    a_neg_c     = bus.a[XLEN-1] && (bus.op[2:0] inside {3'b001, 3'b010, 3'b100, 3'b110});
    b_neg_c     = bus.b[XLEN-1] && (bus.op[2:0] inside {3'b001, 3'b100, 3'b110});
    a_mag_c     = a_neg_c ? -bus.a : bus.a;
    b_mag_c     = b_neg_c ? -bus.b : bus.b;
    div_zero_c  = bus.op[2] && (bus.b == '0);
    div_ovf_c   = bus.op[2] && !bus.op[0] && (bus.a == MIN_NEG) && (bus.b == '1);
    early_res_c = div_zero_c ? (bus.op[1] ? bus.a : '1) : (bus.op[1] ? '0 : bus.a);
  end

  // One shift-add or restoring-divide step; sign fixed on the step's output.
  always_comb begin
    sum_c  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    rs_c   = {hi_q, lo_q[XLEN-1]};
    diff_c = rs_c - {1'b0, opnd_q};
    if (mop_q[2]) begin
      iter_hi_c = diff_c[XLEN] ? rs_c[XLEN-1:0] : diff_c[XLEN-1:0];
      iter_lo_c = {lo_q[XLEN-2:0], ~diff_c[XLEN]};
    end else begin
      iter_hi_c = sum_c[XLEN:1];
      iter_lo_c = {sum_c[0], lo_q[XLEN-1:1]};
    end
    prod_mag_c = {iter_hi_c, iter_lo_c};
    prod_c     = neg_q ? -prod_mag_c : prod_mag_c;
    quo_c      = neg_q ? -iter_lo_c : iter_lo_c;
    rem_c      = neg_q ? -iter_hi_c : iter_hi_c;
    case (mop_q)
      3'b000:                 final_res_c = prod_c[XLEN-1:0];
      3'b001, 3'b010, 3'b011: final_res_c = prod_c[2*XLEN-1:XLEN];
      3'b100, 3'b101:         final_res_c = quo_c;
      default:                final_res_c = rem_c;
    endcase
  end

  // Iterative datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q   <= '0;
      lo_q   <= '0;
      opnd_q <= '0;
      mop_q  <= '0;
      neg_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      opnd_q <= opnd_d;
      mop_q  <= mop_d;
      neg_q  <= neg_d;
      cnt_q  <= cnt_d;
    end
  end
`endif

  // Next-state and result capture.
  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    cmp_d     = cmp_q;
    illegal_d = illegal_q;
`ifdef SEQ_ALU_M_EN
    hi_d   = hi_q;
    lo_d   = lo_q;
    opnd_d = opnd_q;
    mop_d  = mop_q;
    neg_d  = neg_q;
    cnt_d  = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          cmp_d     = 1'b0;
          illegal_d = 1'b0;
          state_d   = DONE;
          if (!bus.op[4]) begin
            result_d = base_res_c;
            cmp_d    = base_cmp_c;
          end
`ifdef SEQ_ALU_M_EN
          else if (div_zero_c || div_ovf_c) begin
            result_d = early_res_c;
          end else begin
            mop_d   = bus.op[2:0];
            neg_d   = (bus.op[2] && bus.op[1]) ? a_neg_c : (a_neg_c ^ b_neg_c);
            cnt_d   = '0;
            hi_d    = '0;
            lo_d    = bus.op[2] ? a_mag_c : b_mag_c;
            opnd_d  = bus.op[2] ? b_mag_c : a_mag_c;
            state_d = BUSY;
          end
`else
          else begin
            result_d  = '0;
            illegal_d = 1'b1;
          end
`endif
        end
      end
      BUSY: begin
`ifdef SEQ_ALU_M_EN
        hi_d  = iter_hi_c;
        lo_d  = iter_lo_c;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(XLEN - 1)) begin
          result_d = final_res_c;
          state_d  = DONE;
        end
`else
        state_d = IDLE;
`endif
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset wins over accept and out_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      cmp_q       <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d == IDLE);
      out_valid_q <= (state_d == DONE);
      result_q    <= result_d;
      cmp_q       <= cmp_d;
      illegal_q   <= illegal_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.cmp       = cmp_q;
  assign bus.illegal   = illegal_q;
endmodule

// File: tb/tb_seq_alu.sv
// Directed + random bench for seq_alu at XLEN=32 with a result scoreboard.
module tb_seq_alu;
  localparam int unsigned XLEN = 32;

  typedef struct {
    logic [31:0] res;
    logic        cmp;
    logic        ill;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   ncmp = 0;
  int   nfail = 0;
  exp_t sb[$];

  seq_alu_if #(.XLEN(XLEN)) bus();

  seq_alu #(.XLEN(XLEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before timeout");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model written from the ISA definitions.
  function automatic exp_t model(input logic [4:0] op_v, input logic [31:0] a_v, input logic [31:0] b_v);
    exp_t e;
    logic signed [31:0] sa, sbv;
    logic signed [63:0] ps, xa, xb;
    logic [63:0] pu;
    e.res = '0; e.cmp = 1'b0; e.ill = 1'b0; e.lat = 1;
    sa = a_v; sbv = b_v;
    pu = '0; ps = '0; xa = '0; xb = '0;
    if (!op_v[4]) begin
      case (op_v[3:0])
        4'd0:  e.res = a_v + b_v;
        4'd1:  e.res = a_v - b_v;
        4'd2:  e.res = a_v ^ b_v;
        4'd3:  e.res = a_v | b_v;
        4'd4:  e.res = a_v & b_v;
        4'd5:  e.res = a_v << b_v[4:0];
        4'd6:  e.res = a_v >> b_v[4:0];
        4'd7:  e.res = sa >>> b_v[4:0];
        4'd8:  e.res = (sa < sbv) ? 32'd1 : 32'd0;
        4'd9:  e.res = (a_v < b_v) ? 32'd1 : 32'd0;
        4'd10: e.cmp = (a_v == b_v);
        4'd11: e.cmp = (a_v != b_v);
        4'd12: e.cmp = (sa < sbv);
        4'd13: e.cmp = (sa >= sbv);
        4'd14: e.cmp = (a_v < b_v);
        4'd15: e.cmp = (a_v >= b_v);
      endcase
    end else begin
`ifdef SEQ_ALU_M_EN
      e.lat = 33;
      case (op_v[2:0])
        3'd0: begin pu = {32'b0, a_v} * {32'b0, b_v}; e.res = pu[31:0]; end
        3'd1: begin xa = sa; xb = sbv; ps = xa * xb; e.res = ps[63:32]; end
        3'd2: begin xa = sa; xb = {32'b0, b_v}; ps = xa * xb; e.res = ps[63:32]; end
        3'd3: begin pu = {32'b0, a_v} * {32'b0, b_v}; e.res = pu[63:32]; end
        3'd4: begin
          if (b_v == 0) begin e.res = '1; e.lat = 1; end
          else if (a_v == 32'h8000_0000 && b_v == 32'hFFFF_FFFF) begin e.res = a_v; e.lat = 1; end
          else e.res = sa / sbv;
        end
        3'd5: begin
          if (b_v == 0) begin e.res = '1; e.lat = 1; end
          else e.res = a_v / b_v;
        end
        3'd6: begin
          if (b_v == 0) begin e.res = a_v; e.lat = 1; end
          else if (a_v == 32'h8000_0000 && b_v == 32'hFFFF_FFFF) begin e.res = '0; e.lat = 1; end
          else e.res = sa % sbv;
        end
        3'd7: begin
          if (b_v == 0) begin e.res = a_v; e.lat = 1; end
          else e.res = a_v % b_v;
        end
      endcase
`else
      e.ill = 1'b1;
`endif
    end
    return e;
  endfunction

  // Issue one request, check result/latency, hold for 'hold' cycles, then release.
  task automatic do_op(input logic [4:0] op_v, input logic [31:0] a_v, input logic [31:0] b_v, input int hold);
    exp_t e;
    int   lat;
    sb.push_back(model(op_v, a_v, b_v));
    bus.in_valid  = 1'b1;
    bus.op        = op_v;
    bus.a         = a_v;
    bus.b         = b_v;
    bus.out_ready = 1'b0;
    check("in_ready_before_accept", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    lat = 1;
    bus.in_valid = 1'($urandom_range(0, 1));
    bus.op       = 5'($urandom);
    bus.a        = $urandom;
    bus.b        = $urandom;
    while (bus.out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    e = sb.pop_front();
    check("latency", 64'(lat), 64'(e.lat));
    check("result", 64'(bus.result), 64'(e.res));
    check("cmp", 64'(bus.cmp), 64'(e.cmp));
    check("illegal", 64'(bus.illegal), 64'(e.ill));
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'b1;
      bus.a        = $urandom;
      @(posedge clk); #1;
      check("hold_result", 64'(bus.result), 64'(e.res));
      check("hold_out_valid", 64'(bus.out_valid), 64'd1);
      check("hold_in_ready", 64'(bus.in_ready), 64'd0);
    end
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    check("exit_out_valid", 64'(bus.out_valid), 64'd0);
    check("exit_in_ready", 64'(bus.in_ready), 64'd1);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic [4:0]  rop;
    bus.in_valid  = 1'b0;
    bus.op        = '0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_result", 64'(bus.result), 64'd0);
    check("rst_cmp", 64'(bus.cmp), 64'd0);
    check("rst_illegal", 64'(bus.illegal), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // base ops
    do_op(5'b00000, 32'd5, 32'd7, 0);
    do_op(5'b00001, 32'd5, 32'd7, 0);
    do_op(5'b00010, 32'hF0F0_1234, 32'h0FF0_FFFF, 0);
    do_op(5'b00011, 32'hA000_0005, 32'h0500_0050, 0);
    do_op(5'b00100, 32'hDEAD_BEEF, 32'h0F0F_F0F0, 0);
    do_op(5'b00101, 32'd1, 32'h0000_0023, 0);
    do_op(5'b00110, 32'h8000_0000, 32'd31, 0);
    do_op(5'b00111, 32'h8000_0000, 32'hFFFF_FFE4, 0);
    do_op(5'b01000, 32'hFFFF_FFFF, 32'd1, 0);
    do_op(5'b01001, 32'hFFFF_FFFF, 32'd1, 0);
    do_op(5'b01010, 32'h1234_5678, 32'h1234_5678, 0);
    do_op(5'b01011, 32'h1234_5678, 32'h1234_5678, 0);
    do_op(5'b01100, 32'hFFFF_FFFF, 32'd1, 0);
    do_op(5'b01101, 32'h8000_0000, 32'h8000_0000, 0);
    do_op(5'b01110, 32'd1, 32'hFFFF_FFFF, 0);
    do_op(5'b01111, 32'd3, 32'd3, 0);

    // hold the result with out_ready low
    do_op(5'b00000, 32'h7FFF_FFFF, 32'd1, 5);

    // M ops (illegal single-cycle when the extension is absent)
    do_op(5'b10011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    do_op(5'b10000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    do_op(5'b10001, 32'hFFFF_FFF9, 32'd3, 0);
    do_op(5'b10010, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 0);
    do_op(5'b10100, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_op(5'b10101, 32'd9, 32'd0, 0);
    do_op(5'b10110, 32'hFFFF_FFF9, 32'd2, 0);
    do_op(5'b10100, 32'hFFFF_FFEC, 32'd3, 0);
    do_op(5'b10111, 32'd100, 32'd7, 2);
    do_op(5'b10110, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_op(5'b10100, 32'd1, 32'd0, 0);
    do_op(5'b10101, 32'h8000_0000, 32'hFFFF_FFFF, 0);

    // random traffic
    for (int i = 0; i < 24; i++) begin
      ra  = $urandom;
      rb  = (i % 4 == 0) ? ra : $urandom;
      rop = (i % 3 == 2) ? {1'b1, 4'($urandom)} : {1'b0, 4'($urandom)};
      do_op(rop, ra, rb, i % 2);
    end

`ifdef SEQ_ALU_M_EN
    // reset in the middle of an iterative divide
    bus.in_valid = 1'b1; bus.op = 5'b10100; bus.a = 32'd1000; bus.b = 32'd7;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("busy_in_ready", 64'(bus.in_ready), 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("busy_rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("busy_rst_out_valid", 64'(bus.out_valid), 64'd0);
    begin
      int seen = 0;
      for (int i = 0; i < 40; i++) begin
        @(posedge clk); #1;
        if (bus.out_valid === 1'b1) seen++;
      end
      check("busy_rst_no_result", 64'(seen), 64'd0);
    end
`endif

    // reset while DONE, together with out_ready and a new request
    bus.in_valid = 1'b1; bus.op = 5'b00000; bus.a = 32'd40; bus.b = 32'd2;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("pre_rst_out_valid", 64'(bus.out_valid), 64'd1);
    check("pre_rst_result", 64'(bus.result), 64'd42);
    rst = 1'b1; bus.out_ready = 1'b1; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; bus.out_ready = 1'b0; bus.in_valid = 1'b0;
    check("done_rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("done_rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("done_rst_result", 64'(bus.result), 64'd0);
    @(posedge clk); #1;
    check("done_rst_idle", 64'(bus.out_valid), 64'd0);

    // works normally after reset
    do_op(5'b00001, 32'd0, 32'd1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter: XLEN, default 32, operand/result width; legal values 8, 16, 32, 64.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 in_valid  input  1  request present on op/a/b.
REQ-005 in_ready  output  1  block can accept a request this cycle.
REQ-006 op  input  5  operation; op[4]=0 base op per op[3:0], op[4]=1 M-extension op per op[2:0].
REQ-007 a  input  XLEN  operand 1 (rs1).
REQ-008 b  input  XLEN  operand 2 (rs2 or immediate).
REQ-009 out_valid  output  1  result, cmp and illegal are valid.
REQ-010 out_ready  input  1  consumer takes the result this cycle.
REQ-011 result  output  XLEN  registered arithmetic result.
REQ-012 cmp  output  1  registered branch-compare outcome.
REQ-013 illegal  output  1  registered flag: op not supported in this build.

Function
REQ-014 FSM states SHALL be IDLE, BUSY, DONE; in_ready SHALL be 1 only in IDLE.
REQ-015 A request SHALL be accepted when in_valid && in_ready; op, a, b captured that edge.
REQ-016 Base ops (op[4]=0) SHALL go IDLE->DONE: out_valid asserted the cycle after acceptance.
REQ-017 Base encodings: 0000 add, 0001 sub, 0010 xor, 0011 or, 0100 and, 0101 sll, 0110 srl, 0111 sra, 1000 slt, 1001 sltu; add/sub wrap modulo 2^XLEN.
REQ-018 Shifts SHALL use only b[$clog2(XLEN)-1:0] as shift amount; sra replicates a[XLEN-1].
REQ-019 Compare encodings SHALL set cmp and result=0: 1010 eq, 1011 ne, 1100 signed lt, 1101 signed ge, 1110 unsigned lt, 1111 unsigned ge (a==b gives cmp=1 for ge forms).
REQ-020 For non-compare ops cmp SHALL be 0; slt/sltu result SHALL be 0 or 1 zero-extended.
REQ-021 M encodings op[2:0]: 000 mul, 001 mulh, 010 mulhsu, 011 mulhu, 100 div, 101 divu, 110 rem, 111 remu, per RV32M semantics at XLEN.
REQ-022 Multiply SHALL be iterative shift-add on magnitudes, sign fixed at end; BUSY for exactly XLEN cycles, out_valid on cycle XLEN+1 after acceptance.
REQ-023 Divide/remainder SHALL be iterative restoring, one quotient bit per cycle; BUSY exactly XLEN cycles, same latency as multiply.
REQ-024 Divide by zero SHALL skip BUSY (latency 1): div/divu quotient all-ones, rem/remu result = a.
REQ-025 Signed overflow (a=most-negative, b=all-ones) SHALL skip BUSY: div result = a, rem result = 0.
REQ-026 Iteration counter width $clog2(XLEN)+1; BUSY->DONE when counter reaches XLEN.
REQ-027 In DONE, result/cmp/illegal/out_valid SHALL hold stable until out_ready=1; that edge moves DONE->IDLE and clears out_valid.
REQ-028 No new request SHALL be accepted in the cycle DONE is exited; next accept earliest one cycle later.
REQ-029 in_valid, op, a, b changes while BUSY or DONE SHALL have no effect.

Reset
REQ-030 rst=1 at a rising edge SHALL force IDLE, in_ready=1, out_valid=0, result=0, cmp=0, illegal=0, counter=0.
REQ-031 Reset during BUSY or DONE SHALL abandon the operation with no result ever presented.
REQ-032 rst SHALL take priority over acceptance and over out_ready in the same cycle.

Configuration
REQ-033 Macro SEQ_ALU_M_EN defined: M ops behave per REQ-021..REQ-025, illegal always 0.
REQ-034 Macro SEQ_ALU_M_EN undefined: multiplier/divider logic SHALL not be built; any op[4]=1 SHALL complete in 1 cycle with result=0, cmp=0, illegal=1.

Verification
REQ-035 XLEN=32, add a=5 b=7 -> out_valid next cycle, result=12, cmp=0, illegal=0.
REQ-036 op 1111 (bgeu) a=3 b=3 -> cmp=1; op 1100 (blt) a=0xFFFFFFFF b=1 -> cmp=1, result=0.
REQ-037 mulhu a=b=0xFFFFFFFF -> out_valid exactly 33 cycles after accept, result=0xFFFFFFFE; mul same operands -> 0x00000001.
REQ-038 div a=0x80000000 b=0xFFFFFFFF -> 1-cycle latency, result 0x80000000; divu a=9 b=0 -> 0xFFFFFFFF; rem a=-7 b=2 -> 0xFFFFFFFF.
REQ-039 Hold out_ready=0 for 5 cycles after out_valid -> result stable, in_ready=0 throughout; out_ready=1 -> in_ready=1 next cycle.
REQ-040 Assert rst 10 cycles into a div -> next cycle in_ready=1, out_valid=0; build without SEQ_ALU_M_EN, mul -> illegal=1, result=0.
